cluster_search_sequencer: RTL and testbench
===========================================

Name: cluster_search_sequencer

Overview:
- Drives the 1536-pad VFAT priority encoder iteratively to extract up to MXCLUSTERS clusters per bunch crossing.
- Latches the pad valid vector on each BX strobe and presents a masked copy to the encoder.
- Takes back adr/cnt from the encoder, emits one cluster word, clears the found cluster's pads, and re-searches.
- Sits between the trigger-unit pad formation logic and the cluster packer output FIFO.

Parameters:
- MXPADS, 1536, pad vector width.
- MXADRBITS, 11, encoder address width.
- MXCLUSTERS, 8, maximum clusters extracted per BX.
- ENC_LATENCY, 3, clocks from enc_vpfs change to a valid enc_adr/enc_cnt (encoder has 2 internal register stages plus input alignment).

Ports:
- clock  in  1  fabric clock (8x BX).
- global_reset_n  in  1  asynchronous, active-low reset.
- bx_strobe  in  1  one-clock pulse marking a new BX; samples vpfs.
- vpfs  in  MXPADS  pad valid bits for the new BX.
- enc_vpfs  out  MXPADS  masked pad vector to the priority encoder.
- enc_adr  in  MXADRBITS  encoder result address; 0x7FE = no hit.
- enc_cnt  in  3  encoder result count (cluster size minus 1).
- cluster_valid  out  1  one-clock strobe: cluster word valid.
- cluster_adr  out  MXADRBITS  cluster first pad.
- cluster_cnt  out  3  cluster size minus 1.
- cluster_idx  out  3  cluster ordinal within the BX, 0..MXCLUSTERS-1.
- cluster_bxn  out  12  BX tag (see Optional Feature).
- frame_done  out  1  one-clock strobe when search of the current BX ends.
- overflow  out  1  sticky per BX: hits remained after MXCLUSTERS found.
- overrun  out  1  one-clock strobe: bx_strobe arrived before frame_done.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - state=IDLE; enc_vpfs=0, mask=0.
  - cluster_valid=0, cluster_adr=0x7FE, cluster_cnt=0, cluster_idx=0, cluster_bxn=0.
  - frame_done=0, overflow=0, overrun=0.
- States and transitions:
  - IDLE: wait for bx_strobe. On bx_strobe: mask<=vpfs, found<=0, overflow<=0; go ISSUE.
  - ISSUE: enc_vpfs<=mask; wait counter<=ENC_LATENCY-1; go WAIT.
  - WAIT: decrement the counter. At 0, sample enc_adr/enc_cnt and go EVAL.
  - EVAL, on the sampled result:
    - enc_adr==0x7FE or enc_adr>=MXPADS: frame_done=1; go IDLE.
    - found==MXCLUSTERS: overflow<=1; frame_done=1; go IDLE.
    - Otherwise: cluster_valid=1 with adr/cnt/idx=found; found++.
      - Clear mask bits adr..adr+cnt, with the upper bound clipped at MXPADS-1 (no wrap to pad 0).
      - Go ISSUE.
- Per-cluster period is ENC_LATENCY+2 clocks. With defaults: 5 clocks per cluster, 8 clusters = 40 clocks, plus a final empty search.
- bx_strobe in any state other than IDLE:
  - overrun pulses and frame_done pulses in the same clock.
  - The old search is abandoned with no cluster_valid for it; the new vpfs are loaded; go ISSUE.
- bx_strobe in the same clock that EVAL would emit a cluster: bx_strobe wins and the cluster is dropped.
- enc_vpfs holds its value between ISSUE steps. It is cleared to 0 in IDLE one clock after frame_done.
- cluster outputs hold their last value when cluster_valid=0.
- Asynchronous reset mid-search: all state clears immediately and no frame_done is emitted.

Optional Feature:
- Macro: CLUSTER_SEQ_BXN_EN.
- Defined:
  - A 12-bit BX counter increments on every bx_strobe and wraps 4095->0.
  - It resets to 0.
  - It is latched into cluster_bxn on load.
- Undefined: cluster_bxn is tied to 0 and the counter logic is not built.

Test Plan:
- vpfs bit 100 set, bx_strobe; encoder model returns adr=100 cnt=1 then 0x7FE -> one cluster_valid with adr=100, cnt=1, idx=0; mask bits 100,101 cleared; frame_done 10 clocks after bx_strobe (defaults).
- 10 isolated hits at pads 0,10,..,90 -> exactly 8 clusters with idx 0..7 in ascending adr; overflow=1; frame_done after the 9th result.
- Hit at pad 1534, encoder cnt=7 -> mask clears only 1534..1535; bit 0 is untouched (no wrap).
- Empty vpfs -> no cluster_valid; frame_done 5 clocks after bx_strobe; overflow=0.
- Second bx_strobe 12 clocks after the first, with 8 hits pending -> overrun and frame_done pulse together; the new frame starts at idx=0; no stale clusters appear.
- CLUSTER_SEQ_BXN_EN defined, 4097 bx_strobes -> cluster_bxn reads 0 after wrap. Undefined -> cluster_bxn is always 0.

Source files
------------

// File: rtl/cluster_search_sequencer_if.sv
// Pad-in / encoder / cluster-out bundle for cluster_search_sequencer.
// slave is the sequencer side; master is the pad-formation + encoder + packer side.
interface cluster_search_sequencer_if #(
    parameter int MXPADS    = 1536,
    parameter int MXADRBITS = 11
);
    logic                 bx_strobe;
    logic [MXPADS-1:0]    vpfs;
    logic [MXPADS-1:0]    enc_vpfs;
    logic [MXADRBITS-1:0] enc_adr;
    logic [2:0]           enc_cnt;
    logic                 cluster_valid;
    logic [MXADRBITS-1:0] cluster_adr;
    logic [2:0]           cluster_cnt;
    logic [2:0]           cluster_idx;
    logic [11:0]          cluster_bxn;
    logic                 frame_done;
    logic                 overflow;
    logic                 overrun;

    modport slave (
        input  bx_strobe, vpfs, enc_adr, enc_cnt,
        output enc_vpfs, cluster_valid, cluster_adr, cluster_cnt, cluster_idx,
               cluster_bxn, frame_done, overflow, overrun
    );

    modport master (
        output bx_strobe, vpfs, enc_adr, enc_cnt,
        input  enc_vpfs, cluster_valid, cluster_adr, cluster_cnt, cluster_idx,
               cluster_bxn, frame_done, overflow, overrun
    );
endinterface

// File: rtl/cluster_search_sequencer.sv
// Iterative cluster extraction: mask -> encoder -> emit cluster -> clear pads -> repeat.
// Optional BX tagging of cluster words when CLUSTER_SEQ_BXN_EN is defined.
module cluster_search_sequencer #(
    parameter int MXPADS      = 1536,
    parameter int MXADRBITS   = 11,
    parameter int MXCLUSTERS  = 8,
    parameter int ENC_LATENCY = 3
) (
    input  logic clock,
    input  logic global_reset_n,
    cluster_search_sequencer_if.slave sif
);
    localparam int FW = $clog2(MXCLUSTERS + 1);
    localparam int WW = $clog2(ENC_LATENCY) + 1;
    localparam logic [MXADRBITS-1:0] NOHIT  = MXADRBITS'(11'h7FE);
    localparam logic [MXADRBITS-1:0] PADS_A = MXADRBITS'(MXPADS);
    localparam logic [FW-1:0]        MXC    = FW'(MXCLUSTERS);
    localparam logic [WW-1:0]        WLOAD  = WW'(ENC_LATENCY - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, EVAL} state_t;

    state_t               state_q, state_d;
    logic [MXPADS-1:0]    mask_q, mask_d;
    logic [MXPADS-1:0]    enc_vpfs_q, enc_vpfs_d;
    logic [WW-1:0]        wcnt_q, wcnt_d;
    logic [FW-1:0]        found_q, found_d;
    logic [MXADRBITS-1:0] res_adr_q, res_adr_d;
    logic [2:0]           res_cnt_q, res_cnt_d;
    logic                 cv_q, cv_d;
    logic [MXADRBITS-1:0] cadr_q, cadr_d;
    logic [2:0]           ccnt_q, ccnt_d;
    logic [2:0]           cidx_q, cidx_d;
    logic                 fdone_q, fdone_d;
    logic                 ovf_q, ovf_d;
    logic                 ovr_q, ovr_d;
    logic [MXPADS-1:0]    clr;

    // Run of cnt+1 ones starting at the found pad; the shift drops bits past the top pad.
    assign clr = MXPADS'(8'hFF >> (3'd7 - res_cnt_q)) << res_adr_q;

    always_comb begin
        state_d    = state_q;
        mask_d     = mask_q;
        enc_vpfs_d = enc_vpfs_q;
        wcnt_d     = wcnt_q;
        found_d    = found_q;
        res_adr_d  = res_adr_q;
        res_cnt_d  = res_cnt_q;
        cv_d       = 1'b0;
        cadr_d     = cadr_q;
        ccnt_d     = ccnt_q;
        cidx_d     = cidx_q;
        fdone_d    = 1'b0;
        ovf_d      = ovf_q;
        ovr_d      = 1'b0;
        if (sif.bx_strobe) begin
            // A new BX pre-empts whatever is in flight, including a cluster about to be emitted.
            mask_d  = sif.vpfs;
            found_d = '0;
            ovf_d   = 1'b0;
            state_d = ISSUE;
            if (state_q != IDLE) begin
                ovr_d   = 1'b1;
                fdone_d = 1'b1;
            end else begin
                enc_vpfs_d = '0;
            end
        end else begin
            case (state_q)
                IDLE: enc_vpfs_d = '0;
                ISSUE: begin
                    enc_vpfs_d = mask_q;
                    wcnt_d     = WLOAD;
                    state_d    = WAIT;
                end
                WAIT: begin
                    if (wcnt_q == '0) begin
                        res_adr_d = sif.enc_adr;
                        res_cnt_d = sif.enc_cnt;
                        state_d   = EVAL;
                    end else begin
                        wcnt_d = wcnt_q - 1'b1;
                    end
                end
                EVAL: begin
                    if (res_adr_q == NOHIT || res_adr_q >= PADS_A) begin
                        fdone_d = 1'b1;
                        state_d = IDLE;
                    end else if (found_q == MXC) begin
                        ovf_d   = 1'b1;
                        fdone_d = 1'b1;
                        state_d = IDLE;
                    end else begin
                        cv_d    = 1'b1;
                        cadr_d  = res_adr_q;
                        ccnt_d  = res_cnt_q;
                        cidx_d  = 3'(found_q);
                        found_d = found_q + 1'b1;
                        mask_d  = mask_q & ~clr;
                        state_d = ISSUE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge global_reset_n) begin
        if (!global_reset_n) begin
            state_q    <= IDLE;
            mask_q     <= '0;
            enc_vpfs_q <= '0;
            wcnt_q     <= '0;
            found_q    <= '0;
            res_adr_q  <= NOHIT;
            res_cnt_q  <= '0;
            cv_q       <= 1'b0;
            cadr_q     <= NOHIT;
            ccnt_q     <= '0;
            cidx_q     <= '0;
            fdone_q    <= 1'b0;
            ovf_q      <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            mask_q     <= mask_d;
            enc_vpfs_q <= enc_vpfs_d;
            wcnt_q     <= wcnt_d;
            found_q    <= found_d;
            res_adr_q  <= res_adr_d;
            res_cnt_q  <= res_cnt_d;
            cv_q       <= cv_d;
            cadr_q     <= cadr_d;
            ccnt_q     <= ccnt_d;
            cidx_q     <= cidx_d;
            fdone_q    <= fdone_d;
            ovf_q      <= ovf_d;
            ovr_q      <= ovr_d;
        end
    end

`ifdef CLUSTER_SEQ_BXN_EN
    logic [11:0] bxcnt_q, fbxn_q, cbxn_q;

    // The frame keeps the pre-increment count; the cluster word takes it only on emission.
    always_ff @(posedge clock or negedge global_reset_n) begin
        if (!global_reset_n) begin
            bxcnt_q <= '0;
            fbxn_q  <= '0;
            cbxn_q  <= '0;
        end else begin
            if (sif.bx_strobe) begin
                bxcnt_q <= bxcnt_q + 12'd1;
                fbxn_q  <= bxcnt_q;
            end
            if (cv_d) cbxn_q <= fbxn_q;
        end
    end
    assign sif.cluster_bxn = cbxn_q;
`else
    assign sif.cluster_bxn = '0;
`endif

    assign sif.enc_vpfs      = enc_vpfs_q;
    assign sif.cluster_valid = cv_q;
    assign sif.cluster_adr   = cadr_q;
    assign sif.cluster_cnt   = ccnt_q;
    assign sif.cluster_idx   = cidx_q;
    assign sif.frame_done    = fdone_q;
    assign sif.overflow      = ovf_q;
    assign sif.overrun       = ovr_q;
endmodule

// File: tb/tb_cluster_search_sequencer.sv
// Scoreboard bench: a behavioural encoder plus a cluster-list model predict every cluster word
// and frame end; a negedge monitor pops and compares whenever the DUT strobes an output.
module tb_cluster_search_sequencer;
    localparam int MXPADS = 1536, MXADRBITS = 11, MXCLUSTERS = 8, PERIOD = 5;

    typedef struct { int adr; int cnt; int idx; int bxn; } cl_t;
    typedef struct { int cyc; bit ovf; bit ovr; } frm_t;

    logic clock = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_vec = 0, n_err = 0;
    int   bxcnt = 0;
    bit   hi_first = 1'b0;
    int   force_cnt = -1;
    bit   chk_clr = 1'b0;
    logic [13:0] p1 = {11'h7FE, 3'd0}, p2 = {11'h7FE, 3'd0};
    cl_t  exp_cl[$];
    frm_t exp_fr[$];

    cluster_search_sequencer_if #(.MXPADS(MXPADS), .MXADRBITS(MXADRBITS)) sif ();

    cluster_search_sequencer #(.MXPADS(MXPADS), .MXADRBITS(MXADRBITS),
                               .MXCLUSTERS(MXCLUSTERS), .ENC_LATENCY(3)) dut (
        .clock(clock), .global_reset_n(rst_n), .sif(sif));

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // Priority encoder: lowest (or highest) set pad, run length capped at 8, optional forced count.
    function automatic logic [13:0] enc_f(input logic [MXPADS-1:0] v);
        int a, c;
        a = -1;
        if (hi_first) begin
            for (int i = MXPADS - 1; i >= 0; i--) if (v[i]) begin a = i; break; end
        end else begin
            for (int i = 0; i < MXPADS; i++) if (v[i]) begin a = i; break; end
        end
        if (a < 0) return {11'h7FE, 3'd0};
        if (force_cnt >= 0) c = force_cnt;
        else begin
            c = 0;
            while (c < 7 && a + c + 1 < MXPADS && v[a + c + 1]) c++;
        end
        return {11'(a), 3'(c)};
    endfunction

    always @(posedge clock) begin
        p1 <= enc_f(sif.enc_vpfs);
        p2 <= p1;
    end
    assign sif.enc_adr = p2[13:3];
    assign sif.enc_cnt = p2[2:0];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic check_reset();
        chk("rst_valid", 32'(sif.cluster_valid), 0);
        chk("rst_adr",   32'(sif.cluster_adr), 32'h7FE);
        chk("rst_cnt",   32'(sif.cluster_cnt), 0);
        chk("rst_idx",   32'(sif.cluster_idx), 0);
        chk("rst_bxn",   32'(sif.cluster_bxn), 0);
        chk("rst_done",  32'(sif.frame_done), 0);
        chk("rst_ovf",   32'(sif.overflow), 0);
        chk("rst_ovr",   32'(sif.overrun), 0);
        chk("rst_encv",  32'(|sif.enc_vpfs), 0);
    endtask

    // Monitor: every strobe from the DUT must match the head of the matching queue.
    always @(negedge clock) begin
        cl_t  e;
        frm_t f;
        if (!rst_n) chk_clr = 1'b0;
        else begin
            if (chk_clr) chk("enc_vpfs_clear", 32'(|sif.enc_vpfs), 0);
            chk_clr = sif.frame_done && !sif.overrun;
            if (sif.cluster_valid) begin
                if (exp_cl.size() == 0) chk("unexpected_cluster", 32'(sif.cluster_adr), 32'hFFFF);
                else begin
                    e = exp_cl.pop_front();
                    chk("cluster_word",
                        {3'b0, sif.cluster_adr, sif.cluster_cnt, sif.cluster_idx, sif.cluster_bxn},
                        {3'b0, 11'(e.adr), 3'(e.cnt), 3'(e.idx), 12'(e.bxn)});
                end
            end
            if (sif.frame_done) begin
                if (exp_fr.size() == 0) chk("unexpected_frame_done", 32'(cyc), 32'hFFFF);
                else begin
                    f = exp_fr.pop_front();
                    chk("frame_done_cyc", 32'(cyc), 32'(f.cyc));
                    chk("frame_ovf_ovr", {30'b0, sif.overflow, sif.overrun}, {30'b0, f.ovf, f.ovr});
                end
            end else if (sif.overrun) chk("overrun_without_done", 32'(sif.overrun), 0);
        end
    end

    // Predict the frame from the rules, truncated by the next strobe (or reset) gap clocks later.
    task automatic run_frame(input logic [MXPADS-1:0] v, input int gap_in, input bit do_rst);
        logic [MXPADS-1:0] m;
        logic [13:0] r;
        cl_t  lst[$];
        cl_t  e;
        frm_t f;
        int   n, a, c, e1, done_rel, gap;
        bit   ovf;
        m = v; n = 0; ovf = 1'b0;
        forever begin
            r = enc_f(m);
            if (r[13:3] == 11'h7FE) break;
            if (n == MXCLUSTERS) begin ovf = 1'b1; break; end
            a = int'(r[13:3]); c = int'(r[2:0]);
`ifdef CLUSTER_SEQ_BXN_EN
            e.bxn = bxcnt;
`else
            e.bxn = 0;
`endif
            e.adr = a; e.cnt = c; e.idx = n;
            lst.push_back(e);
            for (int i = a; i <= a + c && i < MXPADS; i++) m[i] = 1'b0;
            n++;
        end
        done_rel = PERIOD * (n + 1);
        gap = (gap_in > 0) ? gap_in : done_rel + 1 + int'($urandom_range(0, 2));
        e1  = cyc + 1;
        foreach (lst[k]) if (gap > done_rel || PERIOD * (k + 1) < gap) exp_cl.push_back(lst[k]);
        if (do_rst) begin
            if (done_rel < gap) begin f.cyc = e1 + done_rel; f.ovf = ovf; f.ovr = 0; exp_fr.push_back(f); end
        end else if (gap <= done_rel) begin
            f.cyc = e1 + gap; f.ovf = 0; f.ovr = 1; exp_fr.push_back(f);
        end else begin
            f.cyc = e1 + done_rel; f.ovf = ovf; f.ovr = 0; exp_fr.push_back(f);
        end
        sif.vpfs = v;
        sif.bx_strobe = 1'b1;
        bxcnt = (bxcnt + 1) % 4096;
        @(posedge clock) #1;
        sif.bx_strobe = 1'b0;
        repeat (gap - 1) @(posedge clock) #1;
        if (do_rst) begin
            rst_n = 1'b0;
            #1;
            check_reset();
            bxcnt = 0;
            @(posedge clock) #1;
            rst_n = 1'b1;
        end
    endtask

    function automatic logic [MXPADS-1:0] hits(input int n, input int start, input int step);
        logic [MXPADS-1:0] v;
        v = '0;
        for (int i = 0; i < n; i++) v[start + i * step] = 1'b1;
        return v;
    endfunction

    initial begin
        logic [MXPADS-1:0] v;
        sif.bx_strobe = 1'b0;
        sif.vpfs = '0;
        repeat (2) @(posedge clock) #1;
        check_reset();
        rst_n = 1'b1;
        @(posedge clock) #1;

        run_frame(hits(2, 100, 1), 0, 0);          // one cluster 100/1, done after 10
        run_frame(hits(10, 0, 10), 0, 0);          // 8 clusters then overflow
        hi_first = 1'b1; force_cnt = 7;
        v = '0; v[0] = 1'b1; v[1534] = 1'b1;
        run_frame(v, 0, 0);                        // top clear must not wrap onto pad 0
        hi_first = 1'b0; force_cnt = -1;
        run_frame('0, 0, 0);                       // empty BX
        run_frame(hits(8, 200, 3), 12, 0);         // overrun after two clusters
        run_frame(hits(3, 500, 20), 0, 0);
        run_frame(hits(8, 300, 4), 12, 1);         // reset mid-search

        for (int fr = 0; fr < 40; fr++) begin
            v = '0;
            for (int h = 0; h < int'($urandom_range(0, 12)); h++) begin
                int p;
                p = int'($urandom_range(0, MXPADS - 1));
                for (int w = 0; w < int'($urandom_range(1, 3)) && p + w < MXPADS; w++) v[p + w] = 1'b1;
            end
            hi_first  = ($urandom_range(0, 3) == 0);
            force_cnt = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : -1;
            if (fr != 39 && $urandom_range(0, 4) == 0) run_frame(v, int'($urandom_range(1, 50)), 0);
            else run_frame(v, 0, 0);
        end
        repeat (5) @(posedge clock) #1;
        chk("leftover_clusters", 32'(exp_cl.size()), 0);
        chk("leftover_frames", 32'(exp_fr.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
